// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and constants for the stream packetizer
package stream_pkg;

  localparam int PKT_CNT_W   = 16;
  localparam int BEAT_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } pkt_state_e;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/pkt_beat_cnt.sv
// rtl/pkt_beat_cnt.sv - beat index within a packet with sync clear and last-beat detect
module pkt_beat_cnt
  import stream_pkg::*;
#(
  parameter int SIZE = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [SIZE-1:0] len,
  output logic            is_last
);

  logic [SIZE-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = idx_q + SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // len == 0 means an unbounded packet; the index simply wraps
  assign is_last = (len != '0) && (idx_q == len - SIZE'(1));

endmodule

// File: rtl/stream_packetizer.sv
// rtl/stream_packetizer.sv - AXI-Stream TLAST framing with a registered 2-entry skid output
// Optional PKT_STATS_EN enables pkt_done / pkt_cnt; otherwise both are tied to 0.
module stream_packetizer
  import stream_pkg::*;
#(
  parameter int DATA_W = BEAT_DATA_W,
  parameter int SIZE   = 12
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [SIZE-1:0]      cfg_len,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  pkt_state_e      state_q, state_d;
  logic [SIZE-1:0] len_q, len_d;
  logic [SIZE-1:0] cnt_len;
  logic            is_last, cnt_clr, cnt_en, in_fire;

  beat_t main_q, main_d, skid_q, skid_d, in_beat;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q, ready_d;

  assign in_fire = s_axis_tvalid && ready_q;
  // The first beat of a packet is framed against cfg_len before it is latched
  assign cnt_len = (state_q == IDLE) ? cfg_len : len_q;

  pkt_beat_cnt #(.SIZE(SIZE)) u_beat_cnt (
    .clk     (aclk),
    .rst     (areset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .len     (cnt_len),
    .is_last (is_last)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (in_fire) begin
      if (state_q == IDLE) begin
        len_d = cfg_len;
      end
      if (is_last) begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_en  = 1'b1;
        state_d = BUSY;
      end
    end
  end

  assign in_beat = '{data: s_axis_tdata, last: is_last};

  // Input is only accepted while the skid is empty, so it can never overflow
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || m_axis_tready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tlast  = main_q.last;
  assign m_axis_tvalid = main_valid_q;
  assign busy          = (state_q == BUSY);

`ifdef PKT_STATS_EN
  logic                 done_q, done_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    done_d = main_valid_q && m_axis_tready && main_q.last;
    cnt_d  = cnt_q + {{(PKT_CNT_W-1){1'b0}}, done_d};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pkt_done = done_q;
  assign pkt_cnt  = cnt_q;
`else
  assign pkt_done = 1'b0;
  assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_stream_packetizer.sv
// tb/tb_stream_packetizer.sv - directed self-checking bench for stream_packetizer
module tb_stream_packetizer;

`ifdef PKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        aclk;
  logic        areset;
  logic [11:0] cfg_len;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_cnt;

  int n_vec;
  int n_err;
  int n_done;
  logic [32:0] got[$];

  stream_packetizer dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_len       (cfg_len),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .busy          (busy),
    .pkt_done      (pkt_done),
    .pkt_cnt       (pkt_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Records the output handshake about to happen, then advances one cycle
  task automatic step();
    if (m_tvalid === 1'b1 && m_tready === 1'b1) got.push_back({m_tlast, m_tdata});
    @(posedge aclk);
    #1;
    if (pkt_done === 1'b1) n_done++;
  endtask

  task automatic send(input logic [31:0] d, input bit chk_lat);
    logic acc;
    acc      = 1'b0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = s_tready;
      step();
    end
    chk("accept", acc, 1);
    if (chk_lat) begin
      chk("lat_valid", m_tvalid, 1);
      chk("lat_data", m_tdata, d);
    end
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    repeat (4) step();
  endtask

  task automatic check_got(input int n, input logic [31:0] base, input logic [31:0] mask);
    chk("n_out", got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk("out_data", got[i][31:0], base + i);
      chk("out_last", got[i][32], mask[i]);
    end
    got.delete();
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_done   = 0;
    areset   = 1'b1;
    cfg_len  = 12'd4;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    step();
    step();
    chk("rst_tready", s_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_cnt", pkt_cnt, 0);
    areset = 1'b0;
    step();
    chk("rel_tready", s_tready, 1);

    // basic framing, len 4
    m_tready = 1'b1;
    n_done   = 0;
    for (int i = 0; i < 8; i++) begin
      send(i, 1'b1);
      chk("basic_busy", busy, (i % 4) != 3);
    end
    drain();
    check_got(8, 32'd0, 32'b1000_1000);
    chk("basic_done", n_done, STATS ? 2 : 0);
    chk("basic_cnt", pkt_cnt, STATS ? 2 : 0);

    // single-beat packets
    cfg_len = 12'd1;
    n_done  = 0;
    for (int i = 0; i < 5; i++) begin
      send(32'h100 + i, 1'b1);
      chk("single_busy", busy, 0);
    end
    drain();
    check_got(5, 32'h100, 32'b1_1111);
    chk("single_done", n_done, STATS ? 5 : 0);
    chk("single_cnt", pkt_cnt, STATS ? 7 : 0);

    // backpressure, len 6
    cfg_len = 12'd6;
    send(32'h200, 1'b0);
    send(32'h201, 1'b0);
    m_tready = 1'b0;
    send(32'h202, 1'b0);
    chk("bp_tready_fall", s_tready, 0);
    s_tdata = 32'h203;
    repeat (3) step();
    chk("bp_tready_held", s_tready, 0);
    chk("bp_hold_valid", m_tvalid, 1);
    chk("bp_hold_data", m_tdata, 32'h201);
    m_tready = 1'b1;
    step();
    chk("bp_tready_rise", s_tready, 1);
    chk("bp_next_data", m_tdata, 32'h202);
    send(32'h203, 1'b0);
    send(32'h204, 1'b0);
    send(32'h205, 1'b0);
    drain();
    check_got(6, 32'h200, 32'b10_0000);

    // length change mid-packet
    cfg_len = 12'd4;
    send(32'h300, 1'b1);
    send(32'h301, 1'b1);
    cfg_len = 12'd3;
    for (int i = 2; i < 7; i++) send(32'h300 + i, 1'b1);
    chk("lenchg_busy", busy, 0);
    drain();
    check_got(7, 32'h300, 32'b100_1000);

    // unbounded stream
    cfg_len = 12'd0;
    for (int i = 0; i < 20; i++) begin
      send(32'h400 + i, 1'b1);
      chk("unb_busy", busy, 1);
    end
    drain();
    check_got(20, 32'h400, 32'h0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    chk("unb_rst_busy", busy, 0);

    // reset mid-packet with both buffer entries full
    cfg_len  = 12'd5;
    m_tready = 1'b0;
    send(32'h5A0, 1'b0);
    send(32'h5A1, 1'b0);
    chk("mid_full", s_tready, 0);
    s_tvalid = 1'b0;
    areset   = 1'b1;
    step();
    chk("mid_rst_tready", s_tready, 0);
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tlast", m_tlast, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", pkt_done, 0);
    chk("mid_rst_cnt", pkt_cnt, 0);
    areset   = 1'b0;
    m_tready = 1'b1;
    step();
    chk("mid_rel_tready", s_tready, 1);
    chk("mid_rel_tvalid", m_tvalid, 0);
    got.delete();
    n_done = 0;
    for (int i = 0; i < 5; i++) send(32'h500 + i, 1'b1);
    drain();
    check_got(5, 32'h500, 32'b1_0000);
    chk("mid_done", n_done, STATS ? 1 : 0);
    chk("mid_cnt", pkt_cnt, STATS ? 1 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_packetizer.md
# stream_packetizer

Inserts packet framing into a raw AXI4-Stream beat sequence in the coprocessor stream path. It counts accepted input beats against a programmable length and marks the final beat of each packet with TLAST. It sits directly downstream of the producing stream stage and feeds the DMA/S2MM interface. The output is fully registered through a 2-entry skid buffer, so the block sustains one beat per cycle with no combinational ready path.

## Interface
- DATA_W, 32: stream data width.
- SIZE, 12: width of the packet-length field and the beat counter.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_len  in  SIZE  beats per packet; 0 = unbounded, so TLAST is never asserted.
- s_axis_tdata  in  DATA_W  input data.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready; registered.
- m_axis_tdata  out  DATA_W  output data.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high while a packet is partially accepted.
- pkt_done  out  1  one-cycle pulse when a TLAST beat completes its output handshake.
- pkt_cnt  out  16  number of completed packets (see Configuration).

## Operation
- Input handshake: accept = s_axis_tvalid && s_axis_tready. Output handshake: m_axis_tvalid && m_axis_tready.
- FSM has two states, IDLE and BUSY.
  - IDLE: no beat of the current packet accepted yet.
  - On accept in IDLE: latch cfg_len into len_q and set beat_idx = 0.
    - If the latched len = 1, tag this beat last and stay in IDLE.
    - Otherwise move to BUSY with beat_idx = 1.
  - BUSY: each accept increments beat_idx. The beat accepted when beat_idx == len_q-1 is tagged last; beat_idx then clears to 0 and the FSM returns to IDLE.
- If len_q == 0: stay in BUSY indefinitely, never tag last, and let beat_idx wrap modulo 2^SIZE.
- cfg_len is sampled only on the first beat of a packet. Changes mid-packet take effect from the next packet.
- The last tag is computed on the input side and travels with the data through the buffer.
- busy = (state == BUSY).
- Skid buffer:
  - Main output register plus one skid register; s_axis_tready = !skid_valid (registered).
  - An accept while the main register holds a stalled beat writes the skid register.
  - When the main register drains, the skid contents move to it.
  - Beat order is strictly preserved: no loss, no duplication.

## Timing
- Reset values:
  - s_axis_tready = 0 while areset is high, and 1 in the first cycle after release.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - busy = 0, pkt_done = 0, pkt_cnt = 0.
  - FSM returns to IDLE, beat_idx = 0, len_q = 0.
- Latency: an accepted beat appears on m_axis the next cycle when the buffer is empty.
- Throughput: 1 beat/cycle sustained while m_axis_tready = 1.
- s_axis_tready falls the cycle after the skid register fills. It rises the cycle after the skid register drains.
- m_axis_tvalid, once asserted, stays high with stable tdata/tlast until the handshake completes.
- pkt_done is asserted in the cycle after the tlast handshake.
- Reset mid-packet discards both buffer entries and the partial count. The next accepted beat starts a new packet.

## Configuration
- PKT_STATS_EN defined: pkt_cnt increments on every output handshake with m_axis_tlast = 1 and wraps 0xFFFF→0. pkt_done is active.
- PKT_STATS_EN undefined: pkt_cnt is tied to 0 and pkt_done is tied to 0. The port list is unchanged, and framing/data behaviour is identical.

## Structure
- Shared package `stream_pkg`:
  - FSM state typedef (IDLE, BUSY).
  - Beat struct {data, last}.
  - PKT_CNT_W = 16 constant.
- One sub-module, `pkt_beat_cnt`: SIZE-bit beat index with sync clear, increment-on-enable, and an is_last flag (index == len-1, suppressed when len == 0).
- Skid buffer logic stays inline in the top module.

## Test plan
- Basic framing: cfg_len=4, 8 back-to-back beats 0..7, m_axis_tready=1 -> outputs 0..7 each one cycle after input; tlast on beats 3 and 7; pkt_done pulses twice; pkt_cnt=2.
- Single-beat packets: cfg_len=1, 5 beats -> tlast on every beat; busy stays 0.
- Backpressure: cfg_len=6, hold m_axis_tready=0 for 4 cycles mid-packet -> s_axis_tready drops after 2 beats are buffered; full sequence and tlast position intact once released.
- Length change: cfg_len=4, change it to 3 after beat 1 -> first packet ends at beat 3, second packet ends 3 beats later.
- Unbounded stream: cfg_len=0, 20 beats -> tlast never asserted; busy=1 from beat 0 onward.
- Reset mid-packet: cfg_len=5, 2 beats accepted, then areset pulse -> all outputs at reset values; the next 5 beats form a full packet with tlast on the 5th.
